// File: rtl/memory_control.sv
// Memory controller: arbitrates instruction and data requests onto one RAM port.
// Define MEMCTL_STATS_EN to enable the icount/dcount completion counters.
module memory_control #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              iwait,
    output logic              dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              merr,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready,
    output logic [31:0]       icount,
    output logic [31:0]       dcount
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, DBUSY, IBUSY, DRESP, IRESP} state_t;

    state_t            state, state_nxt;
    logic              last_d, last_d_nxt;
    logic              is_wr, is_wr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] store_nxt, iload_nxt, dload_nxt;
    logic              tmo, tmo_hit;
    logic              iwait_nxt, dwait_nxt, merr_nxt, ren_nxt, wen_nxt;

    assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // State and datapath register; every output is loaded from its precomputed next value
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            is_wr    <= 1'b0;
            cnt      <= '0;
            iwait    <= 1'b1;
            dwait    <= 1'b1;
            iload    <= '0;
            dload    <= '0;
            merr     <= 1'b0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            state    <= state_nxt;
            last_d   <= last_d_nxt;
            is_wr    <= is_wr_nxt;
            cnt      <= cnt_nxt;
            iwait    <= iwait_nxt;
            dwait    <= dwait_nxt;
            iload    <= iload_nxt;
            dload    <= dload_nxt;
            merr     <= merr_nxt;
            ramREN   <= ren_nxt;
            ramWEN   <= wen_nxt;
            ramaddr  <= addr_nxt;
            ramstore <= store_nxt;
        end
    end

    // Next state: alternating arbitration, RAM completion and timeout abort
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        is_wr_nxt  = is_wr;
        cnt_nxt    = cnt;
        addr_nxt   = ramaddr;
        store_nxt  = ramstore;
        iload_nxt  = iload;
        dload_nxt  = dload;
        tmo        = 1'b0;
        unique case (state)
            IDLE: begin
                if (iREN && (last_d || !(dREN || dWEN))) begin
                    state_nxt = IBUSY;
                    addr_nxt  = iaddr;
                    is_wr_nxt = 1'b0;
                end else if (dREN || dWEN) begin
                    state_nxt = DBUSY;
                    addr_nxt  = daddr;
                    store_nxt = dstore;
                    is_wr_nxt = dWEN;
                end
            end
            DBUSY, IBUSY: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (ramready) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == DBUSY) ? DRESP : IRESP;
                    if (state == IBUSY) begin
                        iload_nxt = ramload;
                    end else if (!is_wr) begin
                        dload_nxt = ramload;
                    end
                end else if (tmo_hit) begin
                    cnt_nxt   = '0;
                    tmo       = 1'b1;
                    state_nxt = (state == DBUSY) ? DRESP : IRESP;
                end
            end
            DRESP: begin
                last_d_nxt = 1'b1;
                state_nxt  = IDLE;
            end
            IRESP: begin
                last_d_nxt = 1'b0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs for the coming cycle, decoded from the next state
    always_comb begin
        ren_nxt   = (state_nxt == IBUSY) || ((state_nxt == DBUSY) && !is_wr_nxt);
        wen_nxt   = (state_nxt == DBUSY) && is_wr_nxt;
        iwait_nxt = (state_nxt != IRESP);
        dwait_nxt = (state_nxt != DRESP);
        merr_nxt  = tmo;
    end

`ifdef MEMCTL_STATS_EN
    logic [31:0] icnt, dcnt;

    // Count only responses that were not timeout aborts
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            icnt <= '0;
            dcnt <= '0;
        end else begin
            if ((state == IRESP) && !merr) icnt <= icnt + 32'd1;
            if ((state == DRESP) && !merr) dcnt <= dcnt + 32'd1;
        end
    end

    assign icount = icnt;
    assign dcount = dcnt;
`else
    assign icount = '0;
    assign dcount = '0;
`endif

endmodule

// File: tb/tb_memory_control.sv
// Testbench for memory_control: directed and random transactions against a
// transaction-level model (grant alternation, latency, timeout, loads, counters).
module tb_memory_control;
    localparam int unsigned TMO = 4;

    logic        CLK, RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore;
    logic        iwait, dwait, merr, ramREN, ramWEN, ramready;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload, icount, dcount;

    memory_control #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .merr(merr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready),
        .icount(icount), .dcount(dcount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Model state
    logic        last_d;
    logic [31:0] iload_exp, dload_exp, icnt_exp, dcnt_exp;
    logic [31:0] ref_mem [16];

    // RAM model
    logic [31:0] ram [16];

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (ramWEN && ramready) begin
            ram[ramaddr[5:2]] <= ramstore;
        end
    end

    assign ramload = ramready ? ram[ramaddr[5:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        last_d    = 1'b0;
        iload_exp = '0;
        dload_exp = '0;
        icnt_exp  = '0;
        dcnt_exp  = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic chk_counts();
`ifdef MEMCTL_STATS_EN
        chk("icount", icount, icnt_exp);
        chk("dcount", dcount, dcnt_exp);
`else
        chk("icount_off", icount, 32'd0);
        chk("dcount_off", dcount, 32'd0);
`endif
    endtask

    // One access from an IDLE cycle to the following IDLE cycle.
    // delay = cycles of ramready latency; delay >= TMO means the access times out.
    task automatic xact(input logic ir, input logic dr, input logic dw,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                        input int unsigned delay, input logic hold);
        logic        is_d, is_w, tmo;
        logic [31:0] a;
        logic [3:0]  idx;
        int unsigned busy;
        is_d = (dr || dw) && !(last_d && ir);
        is_w = is_d && dw;
        a    = is_d ? da : ia;
        idx  = a[5:2];
        tmo  = (delay >= TMO);
        busy = tmo ? TMO : delay + 1;

        iREN = ir; dREN = dr; dWEN = dw;
        iaddr = ia; daddr = da; dstore = ds;
        ramready = 1'($urandom_range(0, 1));
        chk("idle_iwait", 32'(iwait), 32'd1);
        chk("idle_dwait", 32'(dwait), 32'd1);
        chk("idle_strobes", 32'({ramREN, ramWEN}), 32'd0);
        @(posedge CLK); #1;
        if (!hold) begin
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom;
        end
        for (int unsigned k = 0; k < busy; k++) begin
            ramready = (k == delay);
            chk("busy_ramREN", 32'(ramREN), 32'(!is_w));
            chk("busy_ramWEN", 32'(ramWEN), 32'(is_w));
            chk("busy_ramaddr", ramaddr, a);
            if (is_w) chk("busy_ramstore", ramstore, ds);
            chk("busy_waits", 32'({iwait, dwait}), 32'd3);
            chk("busy_merr", 32'(merr), 32'd0);
            @(posedge CLK); #1;
        end
        ramready = 1'($urandom_range(0, 1));
        if (!tmo) begin
            if (is_w) begin
                ref_mem[idx] = ds;
            end else if (is_d) begin
                dload_exp = ref_mem[idx];
            end else begin
                iload_exp = ref_mem[idx];
            end
            if (is_d) dcnt_exp++; else icnt_exp++;
        end
        last_d = is_d;
        chk("resp_iwait", 32'(iwait), 32'(is_d));
        chk("resp_dwait", 32'(dwait), 32'(!is_d));
        chk("resp_merr", 32'(merr), 32'(tmo));
        chk("resp_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("resp_iload", iload, iload_exp);
        chk("resp_dload", dload, dload_exp);
        @(posedge CLK); #1;
        chk("after_merr", 32'(merr), 32'd0);
        chk_counts();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t;
        RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramready = 0;
        reset_model();
        @(posedge CLK); #1;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_merr", 32'(merr), 32'd0);
        chk("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk_counts();
        @(posedge CLK); #1;
        RST = 1'b0;

        // Seed a word, then fetch it with zero wait states
        xact(0, 0, 1, 32'h0, 32'h40, 32'h8C22_0004, 0, 0);
        xact(1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0);
        chk("ifetch_word", iload, 32'h8C22_0004);

        // Write with three wait states, then read it back
        xact(0, 0, 1, 32'h0, 32'h100, 32'hDEAD_BEEF, 3, 0);
        chk("write_keeps_dload", dload, 32'd0);
        xact(0, 1, 0, 32'h0, 32'h100, 32'h0, 1, 0);
        chk("readback", dload, 32'hDEAD_BEEF);

        // Simultaneous held requests alternate D, I, D, I
        xact(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 0);
        for (int n = 0; n < 4; n++) xact(1, 1, 0, 32'h48, 32'h104, 32'h0, 0, 1);

        // Timeouts on both sides keep the old load values
        xact(0, 1, 0, 32'h0, 32'h108, 32'h0, 99, 0);
        xact(1, 0, 0, 32'h10C, 32'h0, 32'h0, 99, 0);

        // Read and write together is a write
        xact(0, 1, 1, 32'h0, 32'h110, 32'h1234_5678, 2, 0);
        xact(0, 1, 0, 32'h0, 32'h110, 32'h0, 0, 0);
        chk("rw_is_write", dload, 32'h1234_5678);

        // Asynchronous reset in the middle of an instruction access
        iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0; iaddr = 32'h80; ramready = 1'b0;
        @(posedge CLK); #1;
        chk("pre_reset_ramREN", 32'(ramREN), 32'd1);
        iREN = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("async_ramREN", 32'(ramREN), 32'd0);
        chk("async_iwait", 32'(iwait), 32'd1);
        chk("async_ramaddr", ramaddr, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        reset_model();
        chk("post_reset_iload", iload, 32'd0);

        // Counters: three fetches and two stores after reset
        for (int n = 0; n < 3; n++) xact(1, 0, 0, 32'(n * 4), 32'h0, 32'h0, 32'(n), 0);
        for (int n = 0; n < 2; n++) xact(0, 0, 1, 32'h0, 32'(n * 8), $urandom, 1, 0);
`ifdef MEMCTL_STATS_EN
        chk("stats_icount", icount, 32'd3);
        chk("stats_dcount", dcount, 32'd2);
`else
        chk("stats_icount_off", icount, 32'd0);
        chk("stats_dcount_off", dcount, 32'd0);
`endif

        // Random mix of requests, latencies and timeouts
        for (int n = 0; n < 40; n++) begin
            t = 3'($urandom_range(1, 7));
            xact(t[0], t[1], t[2], $urandom, $urandom, $urandom,
                 $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
